// File: rtl/reg_file_pkg.sv
// ============================================================================
//  reg_file_pkg
//  Shared configuration for the architectural register file: default widths,
//  register count and the "no producer" rename tag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int DEF_REG_COUNT    = 32;
  localparam int DEF_REG_ID_WIDTH = 5;
  localparam int DEF_XLEN         = 32;
  localparam int DEF_ROB_ID_WIDTH = 4;

  // Tag value meaning "no in-flight producer; the stored value is current"
  localparam int TAG_NONE = 0;

  typedef logic [DEF_XLEN-1:0]         reg_t;
  typedef logic [DEF_REG_ID_WIDTH-1:0] reg_id_t;
  typedef logic [DEF_ROB_ID_WIDTH-1:0] rob_id_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_read_port.sv
// ============================================================================
//  reg_file_read_port
//  Combinational tag/value select for one source operand. x0 always reads as
//  ready zero. Optional macro REG_FILE_COMMIT_BYPASS_EN forwards a matching
//  same-cycle commit straight to the issuer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int REG_ID_WIDTH = DEF_REG_ID_WIDTH,
  parameter int XLEN         = DEF_XLEN,
  parameter int ROB_ID_WIDTH = DEF_ROB_ID_WIDTH
) (
  input  logic [REG_ID_WIDTH-1:0] rs,
  input  logic [ROB_ID_WIDTH-1:0] tag,
  input  logic [XLEN-1:0]         value,
  input  logic                    commit_valid,
  input  logic [REG_ID_WIDTH-1:0] commit_rd,
  input  logic [ROB_ID_WIDTH-1:0] commit_dest,
  input  logic [XLEN-1:0]         commit_value,
  output logic [ROB_ID_WIDTH-1:0] q,
  output logic [XLEN-1:0]         v
);

`ifndef REG_FILE_COMMIT_BYPASS_EN
  // Commit inputs only matter when forwarding is built in
  logic unused_commit;
  assign unused_commit = ^{commit_valid, commit_rd, commit_dest, commit_value};
`endif

  // Select stored state, optionally forward a resolving commit, mask x0
  always_comb begin
    q = tag;
    v = value;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    if (commit_valid && (commit_rd == rs) && (tag == commit_dest)) begin
      q = ROB_ID_WIDTH'(TAG_NONE);
      v = commit_value;
    end
`endif
    if (rs == '0) begin
      q = ROB_ID_WIDTH'(TAG_NONE);
      v = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
//  reg_file
//  Architectural register file with rename tags. Accepts ROB commits and
//  flushes, records issuer renames and answers two source lookups per cycle.
//  Optional macro: REG_FILE_COMMIT_BYPASS_EN (commit-to-lookup forwarding).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_COUNT    = DEF_REG_COUNT,
  parameter int REG_ID_WIDTH = DEF_REG_ID_WIDTH,
  parameter int XLEN         = DEF_XLEN,
  parameter int ROB_ID_WIDTH = DEF_ROB_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
  output logic [XLEN-1:0]         vj_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
  output logic [XLEN-1:0]         vk_to_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob,
  input  logic                    reset_from_rob_bus,
  output logic [REG_ID_WIDTH:0]   busy_count
);

  logic [ROB_ID_WIDTH-1:0] tags      [REG_COUNT];
  logic [ROB_ID_WIDTH-1:0] tags_next [REG_COUNT];
  logic [XLEN-1:0]         values    [REG_COUNT];
  logic [REG_ID_WIDTH:0]   busy_next;
  logic                    commit_valid;
  logic                    rename_valid;

  assign commit_valid = rdy && (dest_from_rob != ROB_ID_WIDTH'(TAG_NONE)) && (rd_from_rob != '0);
  assign rename_valid = rdy && valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

  // Next tag state: flush clears everything, otherwise commit-clear then rename (rename wins)
  always_comb begin
    for (int i = 0; i < REG_COUNT; i++) begin
      tags_next[i] = tags[i];
    end
    if (rdy && reset_from_rob_bus) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        tags_next[i] = ROB_ID_WIDTH'(TAG_NONE);
      end
    end else begin
      if (commit_valid && (tags[rd_from_rob] == dest_from_rob)
          && !(rename_valid && (rd_from_issuer == rd_from_rob))) begin
        tags_next[rd_from_rob] = ROB_ID_WIDTH'(TAG_NONE);
      end
      if (rename_valid) begin
        tags_next[rd_from_issuer] = dest_from_issuer;
      end
    end
  end

  // Popcount of the next tag state feeds the registered busy counter
  always_comb begin
    busy_next = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (tags_next[i] != ROB_ID_WIDTH'(TAG_NONE)) begin
        busy_next = busy_next + (REG_ID_WIDTH + 1)'(1);
      end
    end
  end

  // Tag array and busy counter update; rdy low holds tags_next equal to tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        tags[i] <= ROB_ID_WIDTH'(TAG_NONE);
      end
      busy_count <= '0;
    end else if (rdy) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        tags[i] <= tags_next[i];
      end
      busy_count <= busy_next;
    end
  end

  // Value array: commit writes land regardless of tag match or flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        values[i] <= '0;
      end
    end else if (commit_valid) begin
      values[rd_from_rob] <= value_from_rob;
    end
  end

  reg_file_read_port #(
    .REG_ID_WIDTH (REG_ID_WIDTH),
    .XLEN         (XLEN),
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_port_rs1 (
    .rs           (rs1_from_issuer),
    .tag          (tags[rs1_from_issuer]),
    .value        (values[rs1_from_issuer]),
    .commit_valid (commit_valid),
    .commit_rd    (rd_from_rob),
    .commit_dest  (dest_from_rob),
    .commit_value (value_from_rob),
    .q            (qj_to_issuer),
    .v            (vj_to_issuer)
  );

  reg_file_read_port #(
    .REG_ID_WIDTH (REG_ID_WIDTH),
    .XLEN         (XLEN),
    .ROB_ID_WIDTH (ROB_ID_WIDTH)
  ) u_port_rs2 (
    .rs           (rs2_from_issuer),
    .tag          (tags[rs2_from_issuer]),
    .value        (values[rs2_from_issuer]),
    .commit_valid (commit_valid),
    .commit_rd    (rd_from_rob),
    .commit_dest  (dest_from_rob),
    .commit_value (value_from_rob),
    .q            (qk_to_issuer),
    .v            (vk_to_issuer)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
//  tb_reg_file
//  Directed bench for reg_file with hand-computed expectations.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        valid_from_issuer;
  logic [4:0]  rd_from_issuer;
  logic [3:0]  dest_from_issuer;
  logic [4:0]  rs1_from_issuer;
  logic [4:0]  rs2_from_issuer;
  logic [3:0]  qj_to_issuer;
  logic [31:0] vj_to_issuer;
  logic [3:0]  qk_to_issuer;
  logic [31:0] vk_to_issuer;
  logic [3:0]  dest_from_rob;
  logic [4:0]  rd_from_rob;
  logic [31:0] value_from_rob;
  logic        reset_from_rob_bus;
  logic [5:0]  busy_count;

  int vectors;
  int miscompares;

  reg_file dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .valid_from_issuer  (valid_from_issuer),
    .rd_from_issuer     (rd_from_issuer),
    .dest_from_issuer   (dest_from_issuer),
    .rs1_from_issuer    (rs1_from_issuer),
    .rs2_from_issuer    (rs2_from_issuer),
    .qj_to_issuer       (qj_to_issuer),
    .vj_to_issuer       (vj_to_issuer),
    .qk_to_issuer       (qk_to_issuer),
    .vk_to_issuer       (vk_to_issuer),
    .dest_from_rob      (dest_from_rob),
    .rd_from_rob        (rd_from_rob),
    .value_from_rob     (value_from_rob),
    .reset_from_rob_bus (reset_from_rob_bus),
    .busy_count         (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rdy                = 1'b1;
    valid_from_issuer  = 1'b0;
    rd_from_issuer     = '0;
    dest_from_issuer   = '0;
    rs1_from_issuer    = '0;
    rs2_from_issuer    = '0;
    dest_from_rob      = '0;
    rd_from_rob        = '0;
    value_from_rob     = '0;
    reset_from_rob_bus = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
    idle();
    valid_from_issuer = 1'b1;
    rd_from_issuer    = rd;
    dest_from_issuer  = tag;
    tick();
    idle();
  endtask

  task automatic commit(input logic [3:0] tag, input logic [4:0] rd, input logic [31:0] val);
    idle();
    dest_from_rob  = tag;
    rd_from_rob    = rd;
    value_from_rob = val;
    tick();
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    rst = 1'b0;

    // Reset state and lookup
    #12;
    rs1_from_issuer = 5'd5;
    rs2_from_issuer = 5'd0;
    #1;
    check_eq("rst_qj", 32'(qj_to_issuer), 32'd0);
    check_eq("rst_vj", vj_to_issuer, 32'd0);
    check_eq("rst_qk", 32'(qk_to_issuer), 32'd0);
    check_eq("rst_vk", vk_to_issuer, 32'd0);
    check_eq("rst_busy", 32'(busy_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Rename x3 -> 7, then commit it
    rename(5'd3, 4'd7);
    rs1_from_issuer = 5'd3;
    #1;
    check_eq("ren_qj", 32'(qj_to_issuer), 32'd7);
    check_eq("ren_busy", 32'(busy_count), 32'd1);
    commit(4'd7, 5'd3, 32'hDEADBEEF);
    rs1_from_issuer = 5'd3;
    #1;
    check_eq("cmt_qj", 32'(qj_to_issuer), 32'd0);
    check_eq("cmt_vj", vj_to_issuer, 32'hDEADBEEF);
    check_eq("cmt_busy", 32'(busy_count), 32'd0);

    // Stale commit updates value, keeps newer tag
    rename(5'd4, 4'd2);
    rename(5'd4, 4'd5);
    commit(4'd2, 5'd4, 32'h11);
    rs1_from_issuer = 5'd4;
    rs2_from_issuer = 5'd3;
    #1;
    check_eq("stale_qj", 32'(qj_to_issuer), 32'd5);
    check_eq("stale_vj", vj_to_issuer, 32'h11);
    check_eq("stale_qk", 32'(qk_to_issuer), 32'd0);
    check_eq("stale_vk", vk_to_issuer, 32'hDEADBEEF);
    check_eq("stale_busy", 32'(busy_count), 32'd1);

    // Same-cycle rename and matching commit on x6
    rename(5'd6, 4'd3);
    check_eq("x6_busy_pre", 32'(busy_count), 32'd2);
    valid_from_issuer = 1'b1;
    rd_from_issuer    = 5'd6;
    dest_from_issuer  = 4'd9;
    dest_from_rob     = 4'd3;
    rd_from_rob       = 5'd6;
    value_from_rob    = 32'h66;
    rs1_from_issuer   = 5'd6;
    #1;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    check_eq("x6_same_qj", 32'(qj_to_issuer), 32'd0);
    check_eq("x6_same_vj", vj_to_issuer, 32'h66);
`else
    check_eq("x6_same_qj", 32'(qj_to_issuer), 32'd3);
    check_eq("x6_same_vj", vj_to_issuer, 32'd0);
`endif
    tick();
    idle();
    rs1_from_issuer = 5'd6;
    #1;
    check_eq("x6_qj", 32'(qj_to_issuer), 32'd9);
    check_eq("x6_vj", vj_to_issuer, 32'h66);
    check_eq("x6_busy", 32'(busy_count), 32'd2);

    // Flush with branch commit and ignored rename
    rename(5'd1, 4'd2);
    rename(5'd2, 4'd4);
    check_eq("fl_busy_pre", 32'(busy_count), 32'd4);
    reset_from_rob_bus = 1'b1;
    dest_from_rob      = 4'd4;
    rd_from_rob        = 5'd2;
    value_from_rob     = 32'h40;
    valid_from_issuer  = 1'b1;
    rd_from_issuer     = 5'd8;
    dest_from_issuer   = 4'd6;
    tick();
    idle();
    rs1_from_issuer = 5'd2;
    rs2_from_issuer = 5'd8;
    #1;
    check_eq("fl_qj2", 32'(qj_to_issuer), 32'd0);
    check_eq("fl_vj2", vj_to_issuer, 32'h40);
    check_eq("fl_qk8", 32'(qk_to_issuer), 32'd0);
    rs1_from_issuer = 5'd4;
    rs2_from_issuer = 5'd1;
    #1;
    check_eq("fl_qj4", 32'(qj_to_issuer), 32'd0);
    check_eq("fl_vj4", vj_to_issuer, 32'h11);
    check_eq("fl_qk1", 32'(qk_to_issuer), 32'd0);
    check_eq("fl_busy", 32'(busy_count), 32'd0);

    // rdy low freezes rename and commit
    rdy               = 1'b0;
    valid_from_issuer = 1'b1;
    rd_from_issuer    = 5'd9;
    dest_from_issuer  = 4'd1;
    dest_from_rob     = 4'd1;
    rd_from_rob       = 5'd5;
    value_from_rob    = 32'h55;
    tick();
    idle();
    rs1_from_issuer = 5'd9;
    rs2_from_issuer = 5'd5;
    #1;
    check_eq("rdy_qj9", 32'(qj_to_issuer), 32'd0);
    check_eq("rdy_vk5", vk_to_issuer, 32'd0);
    check_eq("rdy_busy", 32'(busy_count), 32'd0);

    // x0 is never renamed nor written
    valid_from_issuer = 1'b1;
    rd_from_issuer    = 5'd0;
    dest_from_issuer  = 4'd3;
    dest_from_rob     = 4'd1;
    rd_from_rob       = 5'd0;
    value_from_rob    = 32'd5;
    tick();
    idle();
    rs1_from_issuer = 5'd0;
    rs2_from_issuer = 5'd0;
    #1;
    check_eq("x0_qj", 32'(qj_to_issuer), 32'd0);
    check_eq("x0_vj", vj_to_issuer, 32'd0);
    check_eq("x0_vk", vk_to_issuer, 32'd0);
    check_eq("x0_busy", 32'(busy_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
